// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity mode codes,
// receiver FSM encoding and the majority-of-3 bit decision.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } rx_state_e;

  // Two-of-three vote used to decide each received bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO for received words. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// UART receiver with oversampled start detection, 3-sample majority per
// bit, optional parity, 1-2 stop bits and a word FIFO on the output.
//
// Pop handshake: valid=1 whenever the FIFO holds a word; data/frameErr/
// parityErr describe the head word and stay stable while valid & !ready;
// the head word is removed on the clk edge where valid & ready are both 1.
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] data,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  input  logic                 clrOverrun,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = 4;
  localparam int FW    = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_M_LO  = SC_W'(OVERSAMPLE/2 - 1);
  localparam logic [SC_W-1:0]  SC_M     = SC_W'(OVERSAMPLE/2);
  localparam logic [SC_W-1:0]  SC_M_HI  = SC_W'(OVERSAMPLE/2 + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic             PAR_ODD  = (PARITY == PARITY_ODD);

  logic [1:0]           sync_q, sync_d;
  logic [DIV_W-1:0]     div_q, div_d;
  rx_state_e            state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 armed_q, armed_d;
  logic                 overrun_q, overrun_d;

  logic          rx_s;
  logic          tick;
  logic          maj;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] head;

  assign rx_s = sync_q[1];
  assign tick = (div_q == DIV_LAST);

  // Two-flop synchroniser for the asynchronous line and free-running baud divider.
  always_comb begin
    sync_d = {sync_q[0], rxIn};
    div_d  = tick ? '0 : div_q + DIV_W'(1);
  end

  // Receiver FSM: next state, bit sampling, shift register and error flags.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    armed_d   = armed_q;
    push      = 1'b0;
    maj       = majority3(samp_q[0], samp_q[1], rx_s);

    if (tick && state_q != ST_IDLE && state_q != ST_PUSH) begin
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
      if (sc_q == SC_M_LO) samp_d[0] = rx_s;
      if (sc_q == SC_M)    samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        // A start is only accepted after the line was seen high here,
        // so a held-low line cannot retrigger frames.
        if (tick) begin
          if (!rx_s && armed_q) begin
            state_d   = ST_START;
            sc_d      = '0;
            armed_d   = 1'b0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
      end
      ST_START: begin
        if (tick) begin
          if (sc_q == SC_M_HI && maj) begin
            state_d = ST_IDLE;
          end else if (sc_q == SC_LAST) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sc_q == SC_M_HI) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (sc_q == SC_LAST) begin
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (sc_q == SC_M_HI) par_err_d = ((^shift_q) ^ maj) != PAR_ODD;
          if (sc_q == SC_LAST) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end
        end
      end
      ST_STOP: begin
        // Leave at mid-bit of the last stop bit so the next start edge is caught.
        if (tick) begin
          if (sc_q == SC_M_HI) begin
            if (!maj) frm_err_d = 1'b1;
            if (idx_q == IDX_W'(STOP_BITS - 1)) begin
              state_d = ST_PUSH;
              sc_d    = '0;
            end
          end else if (sc_q == SC_LAST) begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overrun: a completed word that found the FIFO full and not draining.
  always_comb begin
    pop       = ~fifo_empty & ready;
    overrun_d = overrun_q;
    if (clrOverrun) overrun_d = 1'b0;
    if (push && fifo_full && !pop) overrun_d = 1'b1;
  end

  // All receiver state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync_q    <= 2'b11;
      div_q     <= '0;
      state_q   <= ST_IDLE;
      sc_q      <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      div_q     <= div_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      armed_q   <= armed_d;
      overrun_q <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rstN),
    .push    (push),
    .wr_data ({par_err_q, frm_err_q, shift_q}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid     = ~fifo_empty;
  assign data      = valid ? head[DATA_BITS-1:0] : '0;
  assign frameErr  = valid & head[DATA_BITS];
  assign parityErr = valid & head[DATA_BITS+1];
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Directed bench for uart_rx_fifo_core: instance a is 8N1, instance b is 8E1,
// both with CLK_DIV=4 and OVERSAMPLE=16 (64 clk per bit).
module tb_uart_rx_fifo_core;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       frame_err_a, frame_err_b, parity_err_a, parity_err_b;
  logic       valid_a, valid_b, overrun_a, overrun_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Words seen leaving each FIFO: {parityErr, frameErr, data}.
  logic [9:0] got_a_q[$];
  logic [9:0] got_b_q[$];
  logic [9:0] exp_q[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_rx_fifo_core #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .rstN(rstN), .rxIn(rx_a), .data(data_a), .frameErr(frame_err_a),
    .parityErr(parity_err_a), .valid(valid_a), .ready(ready_a), .overrun(overrun_a),
    .clrOverrun(clr_a), .busy(busy_a)
  );

  uart_rx_fifo_core #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .rstN(rstN), .rxIn(rx_b), .data(data_b), .frameErr(frame_err_b),
    .parityErr(parity_err_b), .valid(valid_b), .ready(ready_b), .overrun(overrun_b),
    .clrOverrun(clr_b), .busy(busy_b)
  );

  // Pop monitor: a word sampled here leaves on the next rising edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) got_a_q.push_back({parity_err_a, frame_err_a, data_a});
    if (valid_b && ready_b) got_b_q.push_back({parity_err_b, frame_err_b, data_b});
  end

  // Driver tasks; all of them start and end 1 time unit after a rising edge.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_b = v; else rx_a = v;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (with_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic wait_words(input bit sel, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      if ((sel ? got_b_q.size() : got_a_q.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      wait_clk(1);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    wait_clk(3);
    rstN = 1'b1;
    checks++;
    if ({valid_a, busy_a, overrun_a, frame_err_a, parity_err_a, data_a} !== 13'd0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0",
               {valid_a, busy_a, overrun_a, frame_err_a, parity_err_a, data_a});
    end
    checks++;
    if ({valid_b, busy_b, overrun_b, frame_err_b, parity_err_b, data_b} !== 13'd0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0",
               {valid_b, busy_b, overrun_b, frame_err_b, parity_err_b, data_b});
    end
    wait_clk(2 * BIT_CLK);
  endtask

  task automatic test_basic_8n1();
    bit ok;
    got_a_q.delete();
    ready_a = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_words(1'b0, 1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_arrive: got no word expected 1 word"); end
    checks++;
    if (ok && got_a_q[0] !== {2'b00, 8'hA5}) begin
      errors++; $display("FAIL basic_word: got %h expected %h", got_a_q[0], {2'b00, 8'hA5});
    end
    wait_clk(BIT_CLK);
    checks++;
    if (got_a_q.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d words expected 1", got_a_q.size());
    end
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun_a); end
    ready_a = 1'b0;
  endtask

  task automatic test_parity_even();
    bit ok;
    got_b_q.delete();
    ready_b = 1'b1;
    // 0x03 has two ones; even parity wants bit 0, so bit 1 is an error.
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    wait_words(1'b1, 2, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL parity_arrive: got %0d words expected 2", got_b_q.size()); end
    checks++;
    if (ok && got_b_q[0] !== {2'b10, 8'h03}) begin
      errors++; $display("FAIL parity_bad: got %h expected %h", got_b_q[0], {2'b10, 8'h03});
    end
    checks++;
    if (ok && got_b_q[1] !== {2'b00, 8'h03}) begin
      errors++; $display("FAIL parity_good: got %h expected %h", got_b_q[1], {2'b00, 8'h03});
    end
    ready_b = 1'b0;
  endtask

  task automatic test_frame_err();
    bit ok;
    got_a_q.delete();
    ready_a = 1'b1;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    // The line has to rise once after a low stop bit before a new start counts.
    wait_clk(BIT_CLK);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_words(1'b0, 2, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_arrive: got %0d words expected 2", got_a_q.size()); end
    checks++;
    if (ok && got_a_q[0] !== {2'b01, 8'h3C}) begin
      errors++; $display("FAIL frame_err_word: got %h expected %h", got_a_q[0], {2'b01, 8'h3C});
    end
    checks++;
    if (ok && got_a_q[1] !== {2'b00, 8'h5A}) begin
      errors++; $display("FAIL frame_next_word: got %h expected %h", got_a_q[1], {2'b00, 8'h5A});
    end
    ready_a = 1'b0;
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    bit idle_again = 1'b0;
    rx_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (busy_a) saw_busy = 1'b1;
    end
    rx_a = 1'b1;
    for (int i = 0; i < BIT_CLK; i++) begin
      if (busy_a) saw_busy = 1'b1;
      if (saw_busy && !busy_a) begin idle_again = 1'b1; break; end
      wait_clk(1);
    end
    checks++;
    if (!saw_busy) begin errors++; $display("FAIL glitch_start: got busy 0 expected busy 1 during glitch"); end
    checks++;
    if (!idle_again) begin errors++; $display("FAIL glitch_busy: got busy %b expected 0 within one bit", busy_a); end
    wait_clk(2 * BIT_CLK);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL glitch_push: got valid %b expected 0", valid_a); end
  endtask

  task automatic test_back_to_back_overrun();
    bit ok;
    got_a_q.delete();
    exp_q.delete();
    ready_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      exp_q.push_back({2'b00, 8'(i)});
    end
    wait_clk(4);
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", overrun_a); end
    send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    wait_clk(4);
    checks++;
    if (overrun_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_a); end
    checks++;
    if ({valid_a, data_a} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL ovr_head: got %h expected %h", {valid_a, data_a}, {1'b1, 8'h01});
    end
    clr_a = 1'b1;
    wait_clk(1);
    clr_a = 1'b0;
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_a); end
    ready_a = 1'b1;
    wait_words(1'b0, 4, 20, ok);
    wait_clk(4);
    ready_a = 1'b0;
    checks++;
    if (got_a_q.size() != 4) begin errors++; $display("FAIL ovr_count: got %0d words expected 4", got_a_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_a_q.size() || got_a_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovr_order[%0d]: got %h expected %h", i,
                 (i < got_a_q.size()) ? got_a_q[i] : 10'h3FF, exp_q[i]);
      end
    end
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL ovr_drained: got valid %b expected 0", valid_a); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    got_a_q.delete();
    ready_a = 1'b0;
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    wait_clk(4);
    checks++;
    if (valid_a !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", valid_a); end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    rstN = 1'b0;
    wait_clk(1);
    rstN = 1'b1;
    checks++;
    if ({valid_a, busy_a, overrun_a, frame_err_a, parity_err_a, data_a} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {valid_a, busy_a, overrun_a, frame_err_a, parity_err_a, data_a});
    end
    // Remaining data bits and the stop bit of 0xFF are all high.
    wait_clk(6 * BIT_CLK);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_abandon: got valid %b expected 0", valid_a); end
    ready_a = 1'b1;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_words(1'b0, 1, 200, ok);
    wait_clk(BIT_CLK);
    checks++;
    if (got_a_q.size() != 1 || got_a_q[0] !== {2'b00, 8'h81}) begin
      errors++;
      $display("FAIL rst_next_word: got %0d words first %h expected 1 word %h", got_a_q.size(),
               (got_a_q.size() > 0) ? got_a_q[0] : 10'h3FF, {2'b00, 8'h81});
    end
    ready_a = 1'b0;
  endtask

  task automatic test_break();
    got_a_q.delete();
    ready_a = 1'b1;
    rx_a = 1'b0;
    wait_clk(12 * BIT_CLK);
    checks++;
    if (got_a_q.size() != 1 || got_a_q[0] !== {2'b01, 8'h00}) begin
      errors++;
      $display("FAIL break_word: got %0d words first %h expected 1 word %h", got_a_q.size(),
               (got_a_q.size() > 0) ? got_a_q[0] : 10'h3FF, {2'b01, 8'h00});
    end
    wait_clk(4 * BIT_CLK);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", busy_a); end
    rx_a = 1'b1;
    wait_clk(2 * BIT_CLK);
    checks++;
    if (got_a_q.size() != 1) begin errors++; $display("FAIL break_extra: got %0d words expected 1", got_a_q.size()); end
    ready_a = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    wait_clk(1);
    test_reset();
    test_basic_8n1();
    test_parity_even();
    test_frame_err();
    test_glitch();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
